// File: rtl/bpf_buffer_scheduler_if.sv
// Agent-side handshake bundle for the ping/pang/pung buffer scheduler.
interface bpf_buffer_scheduler_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  // Completion pulses from the snooper, filter CPU and forwarder
  logic                 sn_done;
  logic                 cpu_acc;
  logic                 cpu_rej;
  logic                 fwd_done;
  // Buffer grants (00 none, 01 ping, 10 pang, 11 pung) and decision counters
  logic [1:0]           sn_sel;
  logic [1:0]           cpu_sel;
  logic [1:0]           fwd_sel;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic [CNT_WIDTH-1:0] rej_cnt;

  // Agent side: drives pulses, observes grants
  modport master (
    output sn_done, cpu_acc, cpu_rej, fwd_done,
    input  sn_sel, cpu_sel, fwd_sel, acc_cnt, rej_cnt
  );

  // Scheduler side
  modport slave (
    input  sn_done, cpu_acc, cpu_rej, fwd_done,
    output sn_sel, cpu_sel, fwd_sel, acc_cnt, rej_cnt
  );
endinterface

// File: rtl/bpf_buffer_scheduler.sv
// Circulates three packet buffers snooper -> filter CPU -> forwarder -> snooper
// in strict order, grants them to agents and counts accept/reject decisions.
module bpf_buffer_scheduler #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bpf_buffer_scheduler_if.slave   io_bus
);

  localparam int unsigned NBUF = 3;
  localparam int unsigned SELW = 2;
  localparam logic [SELW-1:0] SEL_NONE = 2'b00;
  localparam logic [SELW-1:0] SEL_PING = 2'b01;
  localparam logic [SELW-1:0] SEL_PUNG = 2'b11;

  typedef enum logic [2:0] {
    ST_EMPTY      = 3'd0,
    ST_FILLING    = 3'd1,
    ST_READY_CPU  = 3'd2,
    ST_FILTERING  = 3'd3,
    ST_READY_FWD  = 3'd4,
    ST_FORWARDING = 3'd5,
    ST_SKIP       = 3'd6
  } buf_state_e;

  buf_state_e           r_state     [NBUF];
  buf_state_e           w_state_nxt [NBUF];
  logic [SELW-1:0]      r_sn_ptr, r_cpu_ptr, r_fwd_ptr;
  logic [SELW-1:0]      w_sn_ptr_nxt, w_cpu_ptr_nxt, w_fwd_ptr_nxt;
  logic [CNT_WIDTH-1:0] r_acc_cnt, r_rej_cnt;
  logic [CNT_WIDTH-1:0] w_acc_cnt_nxt, w_rej_cnt_nxt;
  logic [SELW-1:0]      w_sn_idx, w_cpu_idx, w_fwd_idx;
  buf_state_e           w_sn_cur, w_cpu_cur, w_fwd_cur;

  // Pointers hold 01/10/11 only; map to array index 0..2
  function automatic logic [SELW-1:0] f_idx(input logic [SELW-1:0] ptr);
    return ptr - SELW'(1);
  endfunction

  // Round-robin advance 01 -> 10 -> 11 -> 01
  function automatic logic [SELW-1:0] f_adv(input logic [SELW-1:0] ptr);
    return (ptr == SEL_PUNG) ? SEL_PING : ptr + SELW'(1);
  endfunction

  assign w_sn_idx  = f_idx(r_sn_ptr);
  assign w_cpu_idx = f_idx(r_cpu_ptr);
  assign w_fwd_idx = f_idx(r_fwd_ptr);
  assign w_sn_cur  = r_state[w_sn_idx];
  assign w_cpu_cur = r_state[w_cpu_idx];
  assign w_fwd_cur = r_state[w_fwd_idx];

  // State register: buffer states, agent pointers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) r_state[i] <= ST_EMPTY;
      r_sn_ptr  <= SEL_PING;
      r_cpu_ptr <= SEL_PING;
      r_fwd_ptr <= SEL_PING;
      r_acc_cnt <= '0;
      r_rej_cnt <= '0;
    end else begin
      for (int i = 0; i < NBUF; i++) r_state[i] <= w_state_nxt[i];
      r_sn_ptr  <= w_sn_ptr_nxt;
      r_cpu_ptr <= w_cpu_ptr_nxt;
      r_fwd_ptr <= w_fwd_ptr_nxt;
      r_acc_cnt <= w_acc_cnt_nxt;
      r_rej_cnt <= w_rej_cnt_nxt;
    end
  end

  // Next state: each agent acts only on the buffer its pointer names, and
  // the stages each agent reacts to are disjoint, so no buffer sees two writes
  always_comb begin
    for (int i = 0; i < NBUF; i++) w_state_nxt[i] = r_state[i];
    w_sn_ptr_nxt  = r_sn_ptr;
    w_cpu_ptr_nxt = r_cpu_ptr;
    w_fwd_ptr_nxt = r_fwd_ptr;
    w_acc_cnt_nxt = r_acc_cnt;
    w_rej_cnt_nxt = r_rej_cnt;

    // Snooper: claim an empty buffer, release it on sn_done
    if (w_sn_cur == ST_EMPTY) begin
      w_state_nxt[w_sn_idx] = ST_FILLING;
    end else if (w_sn_cur == ST_FILLING && io_bus.sn_done) begin
      w_state_nxt[w_sn_idx] = ST_READY_CPU;
      w_sn_ptr_nxt          = f_adv(r_sn_ptr);
    end

    // Filter CPU: reject wins over a simultaneous accept
    if (w_cpu_cur == ST_READY_CPU) begin
      w_state_nxt[w_cpu_idx] = ST_FILTERING;
    end else if (w_cpu_cur == ST_FILTERING && io_bus.cpu_rej) begin
      w_state_nxt[w_cpu_idx] = ST_SKIP;
      w_rej_cnt_nxt          = r_rej_cnt + CNT_WIDTH'(1);
      w_cpu_ptr_nxt          = f_adv(r_cpu_ptr);
    end else if (w_cpu_cur == ST_FILTERING && io_bus.cpu_acc) begin
      w_state_nxt[w_cpu_idx] = ST_READY_FWD;
      w_acc_cnt_nxt          = r_acc_cnt + CNT_WIDTH'(1);
      w_cpu_ptr_nxt          = f_adv(r_cpu_ptr);
    end

    // Forwarder: rejected buffers are recycled without ever being granted
    if (w_fwd_cur == ST_READY_FWD) begin
      w_state_nxt[w_fwd_idx] = ST_FORWARDING;
    end else if (w_fwd_cur == ST_SKIP) begin
      w_state_nxt[w_fwd_idx] = ST_EMPTY;
      w_fwd_ptr_nxt          = f_adv(r_fwd_ptr);
    end else if (w_fwd_cur == ST_FORWARDING && io_bus.fwd_done) begin
      w_state_nxt[w_fwd_idx] = ST_EMPTY;
      w_fwd_ptr_nxt          = f_adv(r_fwd_ptr);
    end
  end

  // Outputs: grants decoded from registered state, so reset clears them at once
  always_comb begin
    io_bus.sn_sel  = SEL_NONE;
    io_bus.cpu_sel = SEL_NONE;
    io_bus.fwd_sel = SEL_NONE;
    if (w_sn_cur  == ST_FILLING)    io_bus.sn_sel  = r_sn_ptr;
    if (w_cpu_cur == ST_FILTERING)  io_bus.cpu_sel = r_cpu_ptr;
    if (w_fwd_cur == ST_FORWARDING) io_bus.fwd_sel = r_fwd_ptr;
  end

  assign io_bus.acc_cnt = r_acc_cnt;
  assign io_bus.rej_cnt = r_rej_cnt;

endmodule

// File: tb/tb_bpf_buffer_scheduler.sv
// Bench for bpf_buffer_scheduler: vector table, directed corner sequences and
// a randomized run against a queue-based ownership model.
module tb_bpf_buffer_scheduler;
  localparam int unsigned CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  bpf_buffer_scheduler_if #(.CNT_WIDTH(CW)) bus_if ();

  bpf_buffer_scheduler #(.CNT_WIDTH(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each agent owns a FIFO of buffer ids in arrival order
  // and a flag saying whether the head of that FIFO is currently granted.
  typedef struct { int id; bit skip; } fwd_ent_t;
  int         sn_q [$];
  int         cpu_q[$];
  fwd_ent_t   fwd_q[$];
  bit         sn_g, cpu_g, fwd_g;
  logic [CW-1:0] m_acc, m_rej;

  typedef struct {
    logic sn_done, cpu_acc, cpu_rej, fwd_done;
    logic [1:0] e_sn, e_cpu, e_fwd;
    logic [31:0] e_acc, e_rej;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic r, input logic f);
    bus_if.sn_done  = s;
    bus_if.cpu_acc  = a;
    bus_if.cpu_rej  = r;
    bus_if.fwd_done = f;
  endtask

  task automatic tick(input logic s, input logic a, input logic r, input logic f);
    drive(s, a, r, f);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_sel(input string tag, input logic [1:0] es, input logic [1:0] ec,
                            input logic [1:0] ef);
    check({tag, ".sn_sel"},  32'(bus_if.sn_sel),  32'(es));
    check({tag, ".cpu_sel"}, 32'(bus_if.cpu_sel), 32'(ec));
    check({tag, ".fwd_sel"}, 32'(bus_if.fwd_sel), 32'(ef));
  endtask

  task automatic model_reset();
    sn_q = '{1, 2, 3};
    cpu_q.delete();
    fwd_q.delete();
    sn_g  = 1'b0;
    cpu_g = 1'b0;
    fwd_g = 1'b0;
    m_acc = '0;
    m_rej = '0;
  endtask

  function automatic logic [1:0] m_sn_sel();
    return sn_g ? 2'(sn_q[0]) : 2'b00;
  endfunction
  function automatic logic [1:0] m_cpu_sel();
    return cpu_g ? 2'(cpu_q[0]) : 2'b00;
  endfunction
  function automatic logic [1:0] m_fwd_sel();
    return fwd_g ? 2'(fwd_q[0].id) : 2'b00;
  endfunction

  // One clock edge: grant decisions see the queues as they were before the edge
  task automatic model_edge(input bit s, input bit a, input bit r, input bit f);
    bit sn_rel, cpu_rel, fwd_rel, fwd_drop;
    bit sn_gn, cpu_gn, fwd_gn;
    int id;
    sn_rel   = sn_g && s;
    cpu_rel  = cpu_g && (a || r);
    fwd_rel  = fwd_g && f;
    fwd_drop = !fwd_g && fwd_q.size() > 0 && fwd_q[0].skip;
    sn_gn    = sn_g  ? !sn_rel  : (sn_q.size() > 0);
    cpu_gn   = cpu_g ? !cpu_rel : (cpu_q.size() > 0);
    fwd_gn   = fwd_g ? !fwd_rel : (fwd_q.size() > 0 && !fwd_q[0].skip);
    if (sn_rel) begin
      id = sn_q.pop_front();
      cpu_q.push_back(id);
    end
    if (cpu_rel) begin
      id = cpu_q.pop_front();
      fwd_q.push_back('{id: id, skip: r});
      if (r) m_rej = m_rej + 1'b1;
      else   m_acc = m_acc + 1'b1;
    end
    if (fwd_rel || fwd_drop) begin
      id = fwd_q.pop_front().id;
      sn_q.push_back(id);
    end
    sn_g  = sn_gn;
    cpu_g = cpu_gn;
    fwd_g = fwd_gn;
  endtask

  task automatic model_compare(input string tag);
    logic [1:0] s, c, f;
    bit dup;
    expect_sel(tag, m_sn_sel(), m_cpu_sel(), m_fwd_sel());
    check({tag, ".acc_cnt"}, bus_if.acc_cnt, m_acc);
    check({tag, ".rej_cnt"}, bus_if.rej_cnt, m_rej);
    s = bus_if.sn_sel;
    c = bus_if.cpu_sel;
    f = bus_if.fwd_sel;
    dup = (s != 2'b00 && (s == c || s == f)) || (c != 2'b00 && c == f);
    check({tag, ".exclusive"}, 32'(dup), 32'd0);
  endtask

  // Leaves the bench one tick after reset release (cycle 0, nothing granted yet)
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Cycle-by-cycle vectors from reset release: inputs driven in that cycle,
    // outputs expected in that same cycle (before the edge consuming the inputs)
    //              sn a  r  f   sn     cpu    fwd    acc rej
    vecs[0]  = '{0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0};
    vecs[3]  = '{0, 1, 0, 1, 2'b10, 2'b01, 2'b00, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0};
    vecs[6]  = '{1, 1, 1, 1, 2'b11, 2'b10, 2'b01, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1};
    vecs[8]  = '{0, 1, 0, 0, 2'b01, 2'b11, 2'b00, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2, 1};
    vecs[10] = '{0, 0, 0, 1, 2'b01, 2'b00, 2'b11, 2, 1};
    vecs[11] = '{0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2, 1};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_sel("reset_async", 2'b00, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    expect_sel("reset_hold", 2'b00, 2'b00, 2'b00);
    check("reset_hold.acc_cnt", bus_if.acc_cnt, 32'd0);
    check("reset_hold.rej_cnt", bus_if.rej_cnt, 32'd0);

    // Vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      expect_sel(tag, vecs[i].e_sn, vecs[i].e_cpu, vecs[i].e_fwd);
      check({tag, ".acc_cnt"}, bus_if.acc_cnt, vecs[i].e_acc);
      check({tag, ".rej_cnt"}, bus_if.rej_cnt, vecs[i].e_rej);
      tick(vecs[i].sn_done, vecs[i].cpu_acc, vecs[i].cpu_rej, vecs[i].fwd_done);
    end

    // Full / stall: three packets captured, snooper blocked until ping drains
    do_reset();
    tick(0, 0, 0, 0);
    expect_sel("stall_c1", 2'b01, 2'b00, 2'b00);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    expect_sel("stall_c3", 2'b10, 2'b01, 2'b00);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    expect_sel("stall_c5", 2'b11, 2'b01, 2'b00);
    tick(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      expect_sel($sformatf("stall_full%0d", k), 2'b00, 2'b01, 2'b00);
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    expect_sel("stall_acc1", 2'b00, 2'b00, 2'b00);
    check("stall_acc1.acc_cnt", bus_if.acc_cnt, 32'd1);
    tick(0, 0, 0, 0);
    expect_sel("stall_acc2", 2'b00, 2'b10, 2'b01);
    tick(0, 0, 0, 1);
    expect_sel("stall_fwd1", 2'b00, 2'b10, 2'b00);
    tick(0, 0, 0, 0);
    expect_sel("stall_fwd2", 2'b01, 2'b10, 2'b00);

    // Randomized run against the ownership model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit s, a, r, f;
      model_compare("rand");
      s = sn_g  ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      a = cpu_g ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      r = cpu_g ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      f = fwd_g ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      model_edge(s, a, r, f);
      tick(s, a, r, f);
    end

    // Let the snooper fill every buffer while CPU and forwarder stay quiet
    for (int c = 0; c < 30; c++) begin
      bit s;
      model_compare("fill");
      s = sn_g;
      model_edge(s, 1'b0, 1'b0, 1'b0);
      tick(s, 1'b0, 1'b0, 1'b0);
    end

    // Mid-cycle asynchronous reset with all buffers occupied
    #3;
    rst_n = 1'b0;
    #1;
    expect_sel("midreset", 2'b00, 2'b00, 2'b00);
    check("midreset.acc_cnt", bus_if.acc_cnt, 32'd0);
    check("midreset.rej_cnt", bus_if.rej_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_sel("restart_c0", 2'b00, 2'b00, 2'b00);
    tick(0, 0, 0, 0);
    expect_sel("restart_c1", 2'b01, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
